// File: rtl/uart_arb_pkg.sv
// Shared state type and default timing constants for the UART transmit arbiter.
// FRAME_CYCLES default = (CLK_HZ / BAUD) * BITS_PER_FRAME.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT
   } arb_state_e;

   localparam int DATA_W_DEF       = 8;
   localparam int CLK_HZ           = 100_000_000;
   localparam int BAUD             = 9600;
   localparam int BITS_PER_FRAME   = 10;
   localparam int FRAME_CYCLES_DEF = (CLK_HZ / BAUD) * BITS_PER_FRAME;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational winner select: first request at or above ptr, wrapping.
// With UART_ARB_FIXED_PRIO_EN defined the lowest index wins and ptr is ignored.
module uart_arb_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   int start;

`ifdef UART_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;
   assign start      = 0;
`else
   assign start = int'(ptr);
`endif

   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      valid  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (start + i) % NUM_REQ;
         if (!valid && req[IDX_W'(idx)]) begin
            winner = IDX_W'(idx);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources and times each frame itself.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
   parameter int GAP_CYCLES   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic                       tx_start,
   output logic [DATA_W-1:0]          tx_data,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] owner
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int SPAN  = FRAME_CYCLES + GAP_CYCLES;
   localparam int CNT_W = (SPAN > 1) ? $clog2(SPAN) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SPAN - 1);

   generate
      if (FRAME_CYCLES < 1) begin : g_bad_frame
         $error("uart_tx_arbiter: FRAME_CYCLES must be at least 1");
      end
      if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
         $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
      end
   endgenerate

   arb_state_e        state_q;
   logic [NUM_REQ-1:0] ack_q;
   logic               tx_start_q;
   logic [DATA_W-1:0]  tx_data_q;
   logic               busy_q;
   logic [IDX_W-1:0]   owner_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   ptr_d;
   logic [CNT_W-1:0]   cnt_q;

   logic [IDX_W-1:0]   winner;
   logic               pick_valid;
   logic [DATA_W-1:0]  win_data;

   uart_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .winner (winner),
      .valid  (pick_valid)
   );

   assign win_data = req_data[int'(winner)*DATA_W +: DATA_W];

`ifdef UART_ARB_FIXED_PRIO_EN
   assign ptr_d = '0;
`else
   assign ptr_d = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);
`endif

   // The counter holds SPAN-1 during GRANT, so GRANT+WAIT lasts exactly SPAN cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         busy_q     <= 1'b0;
         owner_q    <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
      end else begin
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q    <= GRANT;
                  ack_q      <= NUM_REQ'(1) << winner;
                  tx_start_q <= 1'b1;
                  busy_q     <= 1'b1;
                  tx_data_q  <= win_data;
                  owner_q    <= winner;
                  cnt_q      <= CNT_LOAD;
               end
            end
            GRANT: begin
               ptr_q <= ptr_d;
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= WAIT;
                  cnt_q   <= cnt_q - CNT_W'(1);
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack      = ack_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;
   assign owner    = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a frame-level model checked every clock, plus directed
// scenarios with hand-computed expectations (short frames: FRAME=20, GAP=2).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int N       = 4;
   localparam int DW      = 8;
   localparam int FRAME   = 20;
   localparam int GAP     = 2;
   localparam int SPACING = FRAME + GAP + 1;
`ifdef UART_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    ack;
   logic            tx_start;
   logic [DW-1:0]   tx_data;
   logic            busy;
   logic [1:0]      owner;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (N),
      .DATA_W       (DW),
      .FRAME_CYCLES (FRAME),
      .GAP_CYCLES   (GAP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .busy     (busy),
      .owner    (owner)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;

   // Frame-level model: a grant makes the transmitter busy for FRAME+GAP clocks.
   bit           m_valid = 1'b0;
   int           m_left  = 0;
   int           m_ptr   = 0;
   int           m_owner = 0;
   logic [N-1:0] m_ack   = '0;
   logic         m_start = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic         m_busy  = 1'b0;

   always @(posedge clk) begin
      cycle++;
      m_ack   = '0;
      m_start = 1'b0;
      if (reset) begin
         m_valid = 1'b1;
         m_left  = 0;
         m_ptr   = 0;
         m_owner = 0;
         m_data  = '0;
      end else if (m_left == 0) begin
         for (int i = 0; i < N; i++) begin
            if (!m_start && req[(m_ptr + i) % N]) begin
               m_start = 1'b1;
               m_owner = (m_ptr + i) % N;
               m_ack[m_owner] = 1'b1;
               m_data  = req_data[m_owner*DW +: DW];
            end
         end
         if (m_start) begin
            m_left = FRAME + GAP;
            m_ptr  = FIXED ? 0 : (m_owner + 1) % N;
         end
      end else begin
         m_left--;
      end
      m_busy = (m_left > 0);
   end

   always @(negedge clk) begin
      if (m_valid) begin
         vectors++;
         if (ack !== m_ack || tx_start !== m_start || tx_data !== m_data ||
             busy !== m_busy || owner !== 2'(m_owner)) begin
            miscompares++;
            $display("FAIL model@%0d: got ack=%b start=%b data=%h busy=%b owner=%0d, want ack=%b start=%b data=%h busy=%b owner=%0d",
                     cycle, ack, tx_start, tx_data, busy, owner, m_ack, m_start, m_data, m_busy, m_owner);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, exp);
      end
   endtask

   task automatic wait_start(input string name, input int limit);
      int w = 0;
      while (tx_start !== 1'b1 && w < limit) begin
         step();
         w++;
      end
      if (tx_start !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: no tx_start within %0d cycles, want a grant", name, limit);
      end
   endtask

   task automatic wait_idle(input string name, input int limit);
      int w = 0;
      while (busy !== 1'b0 && w < limit) begin
         step();
         w++;
      end
      if (busy !== 1'b0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: busy still high after %0d cycles, want 0", name, limit);
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, want $finish before 200us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_len;
      int last;
      int n;
      int acks3;
      req      = '0;
      req_data = '0;
      reset    = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_start", int'(tx_start), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_data", int'(tx_data), 0);
      chk("rst_owner", int'(owner), 0);

      // Single request from requester 1.
      req_data[1*DW +: DW] = 8'hA5;
      req = 4'b0010;
      step();
      chk("s1_ack", int'(ack), 'b0010);
      chk("s1_start", int'(tx_start), 1);
      chk("s1_data", int'(tx_data), 'hA5);
      chk("s1_owner", int'(owner), 1);
      req = '0;
      busy_len = (busy === 1'b1) ? 1 : 0;
      for (int k = 0; k < 40 && busy === 1'b1; k++) begin
         step();
         if (busy === 1'b1) busy_len++;
      end
      chk("s1_busy_len", busy_len, FRAME + GAP);

      // All four request continuously after a reset of the pointer.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'h10 + 8'(i);
      req  = 4'b1111;
      last = 0;
      for (int g = 0; g < 5; g++) begin
         wait_start("s2_start", 40);
         chk("s2_owner", int'(owner), g % 4);
         chk("s2_data", int'(tx_data), 'h10 + (g % 4));
         chk("s2_ack", int'(ack), 1 << (g % 4));
         if (g > 0) chk("s2_spacing", cycle - last, SPACING);
         last = cycle;
         if (g == 4) req = '0;
         step();
      end
      wait_idle("s2_idle", 40);

      // Request from requester 2 arrives while requester 0's frame is in progress.
      req_data[0 +: DW] = 8'h33;
      req = 4'b0001;
      wait_start("s3_start0", 5);
      chk("s3_owner0", int'(owner), 0);
      chk("s3_data0", int'(tx_data), 'h33);
      last = cycle;
      req  = '0;
      repeat (5) step();
      req_data[2*DW +: DW] = 8'h77;
      req_data[0 +: DW]    = 8'hEE;
      req[2] = 1'b1;
      step();
      chk("s3_hold_data", int'(tx_data), 'h33);
      chk("s3_no_ack_busy", int'(ack), 0);
      wait_start("s3_start2", 40);
      chk("s3_ack2", int'(ack), 'b0100);
      chk("s3_data2", int'(tx_data), 'h77);
      chk("s3_spacing", cycle - last, SPACING);
      req = '0;

      // Requester 3 withdraws before the arbiter is free again.
      step();
      step();
      req_data[3*DW +: DW] = 8'h5A;
      req = 4'b1000;
      step();
      req = '0;
      wait_idle("s4_idle", 40);
      n = 0;
      for (int k = 0; k < 30; k++) begin
         if (tx_start === 1'b1 || ack !== '0) n++;
         step();
      end
      chk("s4_no_grant", n, 0);

      // Reset in the middle of a frame clears outputs and the pointer.
      req = 4'b0001;
      wait_start("s5_start", 5);
      chk("s5_owner", int'(owner), 0);
      req = '0;
      repeat (11) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("s5_busy", int'(busy), 0);
      chk("s5_start", int'(tx_start), 0);
      chk("s5_data", int'(tx_data), 0);
      chk("s5_owner_rst", int'(owner), 0);
      req = 4'b1001;
      step();
      chk("s5_ack_after_rst", int'(ack), 'b0001);

      // Requesters 0 and 3 held across five frames.
      acks3 = 0;
      for (int g = 0; g < 5; g++) begin
         if (g > 0) begin
            step();
            wait_start("s6_start", 40);
         end
         chk("s6_owner", int'(owner), FIXED ? 0 : ((g % 2 == 1) ? 3 : 0));
         if (ack[3] === 1'b1) acks3++;
      end
      chk("s6_ack3_count", acks3, FIXED ? 0 : 2);
      req = '0;
      step();
      wait_idle("s6_idle", 40);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte sources, such as the switch-bank sender, a status reporter and a debug dumper. Grants one requester at a time using round-robin order. Issues the transmitter's one-cycle transmit strobe with stable data, then times the frame itself, because the transmitter has no busy/done output. Sits between the requesters and the transmitter in the top level and replaces the direct debounced-button-to-transmit connection.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width fed to the transmitter
FRAME_CYCLES, 104160, clocks per full UART frame (10 bits x 10416 clocks at 100 MHz / 9600 baud)
GAP_CYCLES, 16, extra idle clocks inserted between frames

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request level; held until that requester's ack
req_data  in  NUM_REQ*DATA_W  flattened bytes; requester i occupies bits [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-hot, one-cycle pulse: byte accepted
tx_start  out  1  one-cycle strobe to the transmitter's transmit input
tx_data  out  DATA_W  byte to the transmitter's data input; held stable between grants
busy  out  1  high from the grant cycle until return to IDLE
owner  out  $clog2(NUM_REQ)  index of the last granted requester

Behaviour:
- Reset (clk edge with reset=1) forces: state IDLE; ack=0; tx_start=0; tx_data=0; busy=0; owner=0; rr pointer=0; counter=0. Reset is honoured in any state. A frame in progress is abandoned; the top level resets the transmitter on the same signal.
- States: IDLE, GRANT, WAIT.
- IDLE: if req!=0, pick the winner: first set bit at or above the rr pointer, wrapping modulo NUM_REQ. Register req_data[winner] into tx_data and the winner into owner. Go to GRANT. If req==0, stay in IDLE.
- GRANT (exactly 1 cycle): ack[owner]=1, tx_start=1, busy=1. Load counter = FRAME_CYCLES+GAP_CYCLES-1. Set rr pointer = (owner+1) mod NUM_REQ. Go to WAIT.
- WAIT: busy=1, counter decrements each cycle. At counter==0, go to IDLE; busy falls on the IDLE cycle.
- Latency: req sampled in IDLE at edge n gives ack/tx_start high during cycle n+1.
- Minimum spacing between successive tx_start pulses is FRAME_CYCLES+GAP_CYCLES+1 clocks.
- Handshake: a requester must hold req and data until it sees ack. If req is deasserted before ack, no grant occurs for that requester. If req is still high on the IDLE cycle after a grant, it is a new request for a new byte. Requesters drop req on the cycle ack is seen.
- req changes during GRANT/WAIT are ignored; only the IDLE sample matters.
- Simultaneous requests: exactly one ack per grant, never two bits set.
- tx_data is never modified outside the IDLE->GRANT transition.
- Counter width is $clog2(FRAME_CYCLES+GAP_CYCLES). Elaboration must check FRAME_CYCLES>=1 and NUM_REQ>=2.

Optional Feature:
UART_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest index wins and the rr pointer is held at 0.
- Undefined: round-robin as described above.
- Port list is identical in both builds.

Decomposition:
- Package uart_arb_pkg holds: the state enum (IDLE, GRANT, WAIT); the DATA_W default of 8; the default baud constants (CLK_HZ=100_000_000, BAUD=9600, BITS_PER_FRAME=10).
- FRAME_CYCLES defaults are derived from the package constants.
- One natural sub-module: uart_arb_rr_pick. It is combinational. Inputs are req and the pointer. Outputs are winner index and valid. The fixed-priority macro is applied inside it.

Test Plan (FRAME_CYCLES=20, GAP_CYCLES=2, NUM_REQ=4):
- Single request: req=4'b0010, data1=8'hA5 in IDLE, held until ack -> next cycle ack=4'b0010, tx_start=1, tx_data=8'hA5, owner=1. busy stays high 22 cycles, then IDLE.
- All request continuously, data i=8'h10+i -> grant order 0,1,2,3,0. tx_start pulses exactly 23 cycles apart; tx_data 8'h10,11,12,13,10.
- Request during busy: req2 asserted 5 cycles after a grant to req0 -> no ack until IDLE, then ack[2] and tx_data=data2. tx_data stays stable through WAIT even if data0 changes.
- Withdrawal: req3 pulsed for 1 cycle while WAIT is active -> no ack[3] and no tx_start when returning to IDLE with req=0.
- Reset mid-frame: reset=1 for 1 cycle at WAIT counter=10 -> next cycle busy=0, tx_start=0, tx_data=0, owner=0, pointer=0. With req=4'b1001 the next grant goes to 0.
- UART_ARB_FIXED_PRIO_EN defined, req=4'b1001 held continuously -> every grant goes to requester 0; requester 3 is never acked across 5 frames.
